stopwatch_lap_ctrl: RTL and testbench
=====================================

// Module: stopwatch_lap_ctrl
// PURPOSE
//  Parametrised stopwatch core: MM:SS.cc timebase, debounced start/stop and lap/clear buttons,
//  LAP_DEPTH-entry lap memory with recall browsing. Drives six active-low 7-segment digit buses
//  and RGB status LED. Sits between board pushbuttons/switch and the display mux.
// PARAMETERS
//  CLK_HZ          50_000_000  input clock frequency
//  TICK_HZ         100         timebase rate (centiseconds); DIV = CLK_HZ/TICK_HZ, integer, >=2
//  LAP_DEPTH       10          lap entries stored (>=1)
//  DEBOUNCE_CYCLES 500_000     consecutive stable samples before a button level is accepted
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  btn_start_n  in   1   start/stop pushbutton, active-low, asynchronous
//  btn_lap_n    in   1   lap/clear/next pushbutton, active-low, asynchronous
//  mode_recall  in   1   slide switch, 1 = recall mode requested, asynchronous
//  seg_cs,seg_ds,seg_s,seg_ss,seg_m,seg_mm  out 8 each  digit segments {dp,g..a}, active-low
//  led_r,led_g,led_b  out 1  status: r = PAUSED, g = RUN, b = RECALL (exactly one high)
//  led_sec      out  1   blink: toggles each time csec reaches 0 or 50 in RUN
//  lap_count    out  $clog2(LAP_DEPTH+1)  laps stored
//  lap_full     out  1   lap_count == LAP_DEPTH
//  overflow     out  1   sticky: time wrapped past 99:59.99
// BEHAVIOUR
//  Reset (async assert, sync release): state PAUSED, time 00:00.00, tick counter 0, laps cleared,
//   rd_idx 0, overflow 0, led_sec 0, led_r 1; seg_* = 0xC0, seg_s/seg_m = 0x40 (dp lit).
//  Inputs: all three are 2-FF synchronised. Buttons are debounced: accepted level changes after
//   DEBOUNCE_CYCLES identical synced samples. A falling accepted level gives a 1-cycle press pulse.
//   FSM acts in the pulse cycle; registered outputs reflect it on the next edge.
//  Timebase: tick counter 0..DIV-1 runs only in RUN; at DIV-1 it wraps and the time advances 1 cs.
//   Held (not cleared) in PAUSED/RECALL, so resume is phase-exact.
//  Time: csec 0..99, sec 0..59, min 0..99, binary per field. At 99:59.99 the next tick gives
//   00:00.00 and sets overflow (sticky until clear). Digits are tens/units of each field.
//  States:
//   PAUSED: start -> RUN. lap -> clear (time, tick counter, laps, rd_idx, overflow, led_sec = 0).
//    mode_recall = 1 -> RECALL.
//   RUN: start -> PAUSED. lap -> store current time at lap_count, lap_count+1. When lap_full, the
//    lap is dropped and nothing changes. mode_recall is ignored.
//   RECALL: display lap[rd_idx]. lap -> rd_idx = (rd_idx+1) mod lap_count.
//    mode_recall = 0 -> PAUSED (live time shown, rd_idx kept). start is ignored.
//    lap_count == 0: all digits show dash 0xBF; lap press does nothing.
//  Simultaneous presses, same cycle:
//   RUN: the lap is stored (pre-stop time), then PAUSED.
//   PAUSED: start wins, no clear.
//   RECALL: the lap press is processed; start is ignored.
//  Entering RUN from PAUSED resets rd_idx to 0. Stored laps hold the time value, not the glyph.
//  Display: seg_s and seg_m always have dp lit (bit7 = 0); all other digits have bit7 = 1.
//   Glyphs 0..9 = C0 F9 A4 B0 99 92 82 F8 80 90. Outputs are registered.
//  Reset mid-operation (any state, mid-debounce) returns everything to the reset values above;
//   a button held through reset gives no press until it is released and pressed again.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEBOUNCE_CYCLES=4, LAP_DEPTH=3)
//  1 press start, run 1234 clocks, press start -> PAUSED; time 00:01.23; seg_cs=B0, seg_ds=A4,
//    seg_s=79; led_r=1.
//  2 RUN, lap at 0.05 s, 0.10 s, 0.15 s, 0.20 s -> lap_count=3, lap_full=1, 4th lap dropped.
//    Stop, set mode_recall=1 -> shows 00:00.05; laps -> 0.10, 0.15, 0.05 (wrap).
//  3 force time 99:59.99 in RUN, 10 clocks -> 00:00.00, overflow=1. PAUSED+lap -> overflow=0,
//    lap_count=0.
//  4 3-cycle glitch on btn_start_n -> no state change; 5-cycle press -> exactly one toggle.
//  5 start and lap pulses in same cycle in RUN at 00:00.42 -> lap[0]=00:00.42, state PAUSED;
//    same in PAUSED -> RUN, laps kept.
//  6 recall with lap_count=0 -> all seg=BF; assert rst_n mid-RUN -> reset values next cycle.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: MM:SS.cc stopwatch core with debounced start/stop and
// lap/clear buttons, a small lap memory browsed in recall mode, six active-low
// 7-segment digit buses and an RGB status LED.
module stopwatch_lap_ctrl #(
   parameter int CLK_HZ          = 50_000_000,
   parameter int TICK_HZ         = 100,
   parameter int LAP_DEPTH       = 10,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           btn_start_n,
   input  logic                           btn_lap_n,
   input  logic                           mode_recall,
   output logic [7:0]                     seg_cs,
   output logic [7:0]                     seg_ds,
   output logic [7:0]                     seg_s,
   output logic [7:0]                     seg_ss,
   output logic [7:0]                     seg_m,
   output logic [7:0]                     seg_mm,
   output logic                           led_r,
   output logic                           led_g,
   output logic                           led_b,
   output logic                           led_sec,
   output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
   output logic                           lap_full,
   output logic                           overflow
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int TW  = $clog2(DIV);
   localparam int CW  = $clog2(LAP_DEPTH + 1);
   localparam int IW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_PAUSED = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_RECALL = 2'd2;

   logic [2:0]    sync1_reg, sync2_reg;
   logic [1:0]    btn_press;
   logic          start_p, lap_p, recall_req;
   logic [1:0]    state_reg;
   logic [TW-1:0] tick_reg;
   logic [6:0]    csec_reg, min_reg;
   logic [5:0]    sec_reg;
   logic          overflow_reg, led_sec_reg;
   logic [CW-1:0] lap_count_reg;
   logic [IW-1:0] rd_idx_reg;
   logic          full_w, lap_we, tick_wrap;
   logic [19:0]   lap_mem [LAP_DEPTH];
   logic [19:0]   lap_rd_reg;
   logic [6:0]    disp_csec, disp_min;
   logic [5:0]    disp_sec;

   // Two-flop synchronisers; buttons start out "pressed" so a button held
   // through reset never produces a press until it has been released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= {mode_recall, btn_lap_n, btn_start_n};
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_db
         logic [DBW-1:0] cnt_reg;
         logic           level_reg, press_reg;
         // Accept a new level after DEBOUNCE_CYCLES identical samples; pulse on press.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               press_reg <= 1'b0;
            end else begin
               press_reg <= 1'b0;
               if (sync2_reg[gi] == level_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DB_LAST) begin
                  cnt_reg   <= '0;
                  level_reg <= sync2_reg[gi];
                  press_reg <= ~sync2_reg[gi];
               end else begin
                  cnt_reg <= cnt_reg + DBW'(1);
               end
            end
         end
         assign btn_press[gi] = press_reg;
      end
   endgenerate

   assign start_p    = btn_press[0];
   assign lap_p      = btn_press[1];
   assign recall_req = sync2_reg[2];
   assign full_w     = (lap_count_reg == CW'(LAP_DEPTH));
   assign lap_we     = (state_reg == ST_RUN) && lap_p && !full_w;
   assign tick_wrap  = (state_reg == ST_RUN) && (tick_reg == TW'(DIV - 1));

   // Timebase, time fields, lap bookkeeping and the PAUSED/RUN/RECALL state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_PAUSED;
         tick_reg      <= '0;
         csec_reg      <= '0;
         sec_reg       <= '0;
         min_reg       <= '0;
         overflow_reg  <= 1'b0;
         led_sec_reg   <= 1'b0;
         lap_count_reg <= '0;
         rd_idx_reg    <= '0;
      end else begin
         if (state_reg == ST_RUN) begin
            if (tick_wrap) begin
               tick_reg <= '0;
               if (csec_reg == 7'd49 || csec_reg == 7'd99)
                  led_sec_reg <= ~led_sec_reg;
               if (csec_reg == 7'd99) begin
                  csec_reg <= '0;
                  if (sec_reg == 6'd59) begin
                     sec_reg <= '0;
                     if (min_reg == 7'd99) begin
                        min_reg      <= '0;
                        overflow_reg <= 1'b1;
                     end else begin
                        min_reg <= min_reg + 7'd1;
                     end
                  end else begin
                     sec_reg <= sec_reg + 6'd1;
                  end
               end else begin
                  csec_reg <= csec_reg + 7'd1;
               end
            end else begin
               tick_reg <= tick_reg + TW'(1);
            end
         end
         case (state_reg)
            ST_PAUSED: begin
               if (start_p) begin
                  state_reg  <= ST_RUN;
                  rd_idx_reg <= '0;
               end else if (lap_p) begin
                  tick_reg      <= '0;
                  csec_reg      <= '0;
                  sec_reg       <= '0;
                  min_reg       <= '0;
                  overflow_reg  <= 1'b0;
                  led_sec_reg   <= 1'b0;
                  lap_count_reg <= '0;
                  rd_idx_reg    <= '0;
               end else if (recall_req) begin
                  state_reg <= ST_RECALL;
               end
            end
            ST_RUN: begin
               if (lap_we)
                  lap_count_reg <= lap_count_reg + CW'(1);
               if (start_p)
                  state_reg <= ST_PAUSED;
            end
            ST_RECALL: begin
               if (lap_p && lap_count_reg != '0) begin
                  if (CW'(rd_idx_reg) + CW'(1) == lap_count_reg)
                     rd_idx_reg <= '0;
                  else
                     rd_idx_reg <= rd_idx_reg + IW'(1);
               end
               if (!recall_req)
                  state_reg <= ST_PAUSED;
            end
            default: state_reg <= ST_PAUSED;
         endcase
      end
   end

   // Lap memory: write the pre-edge time on an accepted lap, registered read of rd_idx.
   always_ff @(posedge clk) begin
      if (lap_we)
         lap_mem[lap_count_reg[IW-1:0]] <= {min_reg, sec_reg, csec_reg};
      lap_rd_reg <= lap_mem[rd_idx_reg];
   end

   // Recall shows the selected lap, every other state shows live time.
   always_comb begin
      disp_csec = csec_reg;
      disp_sec  = sec_reg;
      disp_min  = min_reg;
      if (state_reg == ST_RECALL) begin
         disp_min  = lap_rd_reg[19:13];
         disp_sec  = lap_rd_reg[12:7];
         disp_csec = lap_rd_reg[6:0];
      end
   end

   function automatic logic [7:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: glyph = 8'hC0;
         4'd1: glyph = 8'hF9;
         4'd2: glyph = 8'hA4;
         4'd3: glyph = 8'hB0;
         4'd4: glyph = 8'h99;
         4'd5: glyph = 8'h92;
         4'd6: glyph = 8'h82;
         4'd7: glyph = 8'hF8;
         4'd8: glyph = 8'h80;
         4'd9: glyph = 8'h90;
         default: glyph = 8'hFF;
      endcase
   endfunction

   function automatic logic [3:0] tens(input logic [6:0] v);
      tens = 4'(v / 7'd10);
   endfunction

   function automatic logic [3:0] units(input logic [6:0] v);
      units = 4'(v % 7'd10);
   endfunction

   // Registered display and status LEDs; seconds and minutes units carry the lit dp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_cs <= 8'hC0;
         seg_ds <= 8'hC0;
         seg_s  <= 8'h40;
         seg_ss <= 8'hC0;
         seg_m  <= 8'h40;
         seg_mm <= 8'hC0;
         led_r  <= 1'b1;
         led_g  <= 1'b0;
         led_b  <= 1'b0;
      end else begin
         led_r <= (state_reg == ST_PAUSED);
         led_g <= (state_reg == ST_RUN);
         led_b <= (state_reg == ST_RECALL);
         if (state_reg == ST_RECALL && lap_count_reg == '0) begin
            seg_cs <= 8'hBF;
            seg_ds <= 8'hBF;
            seg_s  <= 8'hBF;
            seg_ss <= 8'hBF;
            seg_m  <= 8'hBF;
            seg_mm <= 8'hBF;
         end else begin
            seg_cs <= glyph(units(disp_csec));
            seg_ds <= glyph(tens(disp_csec));
            seg_s  <= glyph(units({1'b0, disp_sec})) & 8'h7F;
            seg_ss <= glyph(tens({1'b0, disp_sec}));
            seg_m  <= glyph(units(disp_min)) & 8'h7F;
            seg_mm <= glyph(tens(disp_min));
         end
      end
   end

   assign led_sec   = led_sec_reg;
   assign lap_count = lap_count_reg;
   assign lap_full  = full_w;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: small parameters (DIV = 10, debounce 4, 3 laps),
// expected display/status snapshots queued as stimulus is applied and compared
// once the design has settled.
module tb_stopwatch_lap_ctrl;

   localparam int LAP_DEPTH = 3;
   localparam logic [2:0] RGB_P   = 3'b100;
   localparam logic [2:0] RGB_RUN = 3'b010;
   localparam logic [2:0] RGB_REC = 3'b001;
   localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic       clk = 1'b0;
   logic       rst_n, btn_start_n, btn_lap_n, mode_recall;
   logic [7:0] seg_cs, seg_ds, seg_s, seg_ss, seg_m, seg_mm;
   logic       led_r, led_g, led_b, led_sec, lap_full, overflow;
   logic [1:0] lap_count;

   always #5 clk = ~clk;

   stopwatch_lap_ctrl #(
      .CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(LAP_DEPTH), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_start_n(btn_start_n), .btn_lap_n(btn_lap_n),
      .mode_recall(mode_recall),
      .seg_cs(seg_cs), .seg_ds(seg_ds), .seg_s(seg_s), .seg_ss(seg_ss),
      .seg_m(seg_m), .seg_mm(seg_mm),
      .led_r(led_r), .led_g(led_g), .led_b(led_b), .led_sec(led_sec),
      .lap_count(lap_count), .lap_full(lap_full), .overflow(overflow)
   );

   typedef struct {
      string      tag;
      int         t;      // shown time in centiseconds
      bit         dash;
      logic [2:0] rgb;
      int         laps;
      bit         ovf;
      bit         lsec;
      bit         chk_t;  // 0 while running: digits are moving
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [47:0] exp_segs(input int t, input bit dash);
      int cs, s, m;
      if (dash) return {6{8'hBF}};
      cs = t % 100;
      s  = (t / 100) % 60;
      m  = t / 6000;
      return {GLYPH[m / 10], GLYPH[m % 10] & 8'h7F, GLYPH[s / 10], GLYPH[s % 10] & 8'h7F,
              GLYPH[cs / 10], GLYPH[cs % 10]};
   endfunction

   task automatic sb_push(input string tag, input int t, input bit dash, input logic [2:0] rgb,
                          input int laps, input bit ovf, input bit lsec, input bit chk_t);
      exp_t e;
      e.tag = tag; e.t = t; e.dash = dash; e.rgb = rgb;
      e.laps = laps; e.ovf = ovf; e.lsec = lsec; e.chk_t = chk_t;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      check_val("sb_depth", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         $display("[%0t] %s: segs=%h rgb=%b laps=%0d full=%b ovf=%b led_sec=%b", $time, e.tag,
                  {seg_mm, seg_m, seg_ss, seg_s, seg_ds, seg_cs}, {led_r, led_g, led_b},
                  lap_count, lap_full, overflow, led_sec);
         if (e.chk_t)
            check_val({e.tag, ".segs"}, 64'({seg_mm, seg_m, seg_ss, seg_s, seg_ds, seg_cs}),
                      64'(exp_segs(e.t, e.dash)));
         check_val({e.tag, ".rgb"}, 64'({led_r, led_g, led_b}), 64'(e.rgb));
         check_val({e.tag, ".laps"}, 64'(lap_count), 64'(e.laps));
         check_val({e.tag, ".full"}, 64'(lap_full), 64'(e.laps == LAP_DEPTH));
         check_val({e.tag, ".ovf"}, 64'(overflow), 64'(e.ovf));
         check_val({e.tag, ".led_sec"}, 64'(led_sec), 64'(e.lsec));
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold the selected buttons low for 8 cycles, then leave 8 cycles to settle.
   task automatic press(input bit s, input bit l);
      if (s) btn_start_n = 1'b0;
      if (l) btn_lap_n = 1'b0;
      cyc(8);
      btn_start_n = 1'b1;
      btn_lap_n   = 1'b1;
      cyc(8);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; btn_start_n = 1'b1; btn_lap_n = 1'b1; mode_recall = 1'b0;
      #2 rst_n = 1'b0;
      cyc(3);
      sb_push("reset", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();
      rst_n = 1'b1;
      cyc(20);

      // 1: run exactly 1234 clocks -> 00:01.23
      press(1, 0);
      cyc(1234 - 16);
      press(1, 0);
      cyc(4);
      sb_push("run_1234", 123, 0, RGB_P, 0, 0, 0, 1);
      sb_check();

      // 2: laps at 0.05/0.10/0.15/0.20 s, fourth dropped, then browse
      press(0, 1);
      sb_push("clear_a", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();
      press(1, 0);
      cyc(39); press(0, 1);
      cyc(34); press(0, 1);
      cyc(34); press(0, 1);
      cyc(34); press(0, 1);
      cyc(29); press(1, 0);
      sb_push("laps_full", 25, 0, RGB_P, 3, 0, 0, 1);
      sb_check();
      mode_recall = 1'b1;
      cyc(12);
      sb_push("recall_0", 5, 0, RGB_REC, 3, 0, 0, 1);
      sb_check();
      press(0, 1);
      sb_push("recall_1", 10, 0, RGB_REC, 3, 0, 0, 1);
      sb_check();
      press(0, 1);
      sb_push("recall_2", 15, 0, RGB_REC, 3, 0, 0, 1);
      sb_check();
      press(0, 1);
      sb_push("recall_wrap", 5, 0, RGB_REC, 3, 0, 0, 1);
      sb_check();
      mode_recall = 1'b0;
      cyc(12);
      sb_push("recall_exit", 25, 0, RGB_P, 3, 0, 0, 1);
      sb_check();

      // 3: wrap past 99:59.99 sets sticky overflow; clear drops it
      press(1, 0);
      force dut.csec_reg = 7'd99;
      force dut.sec_reg  = 6'd59;
      force dut.min_reg  = 7'd99;
      force dut.tick_reg = '0;
      #1;
      release dut.csec_reg;
      release dut.sec_reg;
      release dut.min_reg;
      release dut.tick_reg;
      cyc(11);
      sb_push("wrap", 0, 0, RGB_RUN, 3, 1, 1, 1);
      sb_check();
      press(1, 0);
      press(0, 1);
      sb_push("clear_b", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();

      // 4: 3-cycle glitch ignored, 5-cycle press toggles once
      btn_start_n = 1'b0;
      cyc(3);
      btn_start_n = 1'b1;
      cyc(16);
      sb_push("glitch", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();
      btn_start_n = 1'b0;
      cyc(5);
      btn_start_n = 1'b1;
      cyc(16);
      sb_push("press5", 0, 0, RGB_RUN, 0, 0, 0, 0);
      sb_check();
      press(1, 0);
      press(0, 1);
      sb_push("clear_c", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();

      // 5: simultaneous presses in RUN (lap then stop) and in PAUSED (start wins)
      press(1, 0);
      cyc(425 - 16);
      press(1, 1);
      sb_push("both_run", 42, 0, RGB_P, 1, 0, 0, 1);
      sb_check();
      press(1, 1);
      sb_push("both_paused", 42, 0, RGB_RUN, 1, 0, 0, 0);
      sb_check();
      press(1, 0);
      mode_recall = 1'b1;
      cyc(12);
      sb_push("lap0_42", 42, 0, RGB_REC, 1, 0, 0, 1);
      sb_check();
      mode_recall = 1'b0;
      cyc(12);

      // 6: empty recall shows dashes, reset mid-run, button held through reset
      press(0, 1);
      mode_recall = 1'b1;
      cyc(12);
      sb_push("recall_empty", 0, 1, RGB_REC, 0, 0, 0, 1);
      sb_check();
      press(0, 1);
      sb_push("recall_empty_lap", 0, 1, RGB_REC, 0, 0, 0, 1);
      sb_check();
      mode_recall = 1'b0;
      cyc(12);
      press(1, 0);
      cyc(30);
      rst_n = 1'b0;
      #1;
      sb_push("reset_mid_run", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();
      btn_start_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(30);
      sb_push("held_thru_reset", 0, 0, RGB_P, 0, 0, 0, 1);
      sb_check();
      btn_start_n = 1'b1;
      cyc(16);
      press(1, 0);
      sb_push("press_after_release", 0, 0, RGB_RUN, 0, 0, 0, 0);
      sb_check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
